// File: rtl/flash_read_arbiter.sv
// Read-only controller for an x16 parallel NOR flash shared by two octabyte requesters.
// Port 0 is instruction fetch, port 1 is data load; each octabyte is four big-endian halfwords.
module flash_read_arbiter #(
    parameter int unsigned ADDR_W         = 22,
    parameter int unsigned WAIT_CYCLES    = 5,
    parameter int unsigned RST_CYCLES     = 25,
    parameter int unsigned RECOVER_CYCLES = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-3:0] m0_addr,
    output logic              m0_ack,
    output logic [63:0]       m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-3:0] m1_addr,
    output logic              m1_ack,
    output logic [63:0]       m1_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic [15:0]       flash_dq_in,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic              flash_we_n,
    output logic              flash_rst_n
);

    localparam int unsigned MaxRr  = (RST_CYCLES > RECOVER_CYCLES) ? RST_CYCLES : RECOVER_CYCLES;
    localparam int unsigned CntMax = (MaxRr > WAIT_CYCLES) ? MaxRr : WAIT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] RstLast  = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] RecLast  = CntW'(RECOVER_CYCLES - 1);
    localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {StRstHold, StRecover, StIdle, StAccess, StAck} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        k_q, k_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [47:0]       asm_q, asm_d;
    logic [63:0]       m0_rdata_q, m0_rdata_d;
    logic [63:0]       m1_rdata_q, m1_rdata_d;
    logic              pick;

    // Round-robin only matters on a tie; otherwise the lone requester wins.
    assign pick = (m0_req && m1_req) ? ~last_grant_q : m1_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StRstHold;
            cnt_q        <= '0;
            k_q          <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            asm_q        <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            asm_q        <= asm_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        asm_d        = asm_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        unique case (state_q)
            StRstHold: begin
                if (cnt_q == RstLast) begin
                    state_d = StRecover;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRecover: begin
                if (cnt_q == RecLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StIdle: begin
                if (m0_req || m1_req) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    addr_d       = pick ? m1_addr : m0_addr;
                    k_d          = '0;
                    cnt_d        = '0;
                    state_d      = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == WaitLast) begin
                    cnt_d = '0;
                    k_d   = k_q + 2'd1;
                    unique case (k_q)
                        2'd0: asm_d[47:32] = flash_dq_in;
                        2'd1: asm_d[31:16] = flash_dq_in;
                        2'd2: asm_d[15:0]  = flash_dq_in;
                        2'd3: begin
                            // Last halfword bypasses the assembly register so rdata is
                            // already valid during the ack cycle.
                            if (grant_q) m1_rdata_d = {asm_q, flash_dq_in};
                            else         m0_rdata_d = {asm_q, flash_dq_in};
                            state_d = StAck;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StRstHold;
        endcase
    end

    always_comb begin
        busy        = 1'b1;
        flash_rst_n = 1'b1;
        flash_ce_n  = 1'b1;
        flash_oe_n  = 1'b1;
        flash_addr  = '0;
        m0_ack      = 1'b0;
        m1_ack      = 1'b0;
        unique case (state_q)
            StRstHold: flash_rst_n = 1'b0;
            StIdle:    busy = 1'b0;
            StAccess: begin
                flash_ce_n = 1'b0;
                flash_oe_n = 1'b0;
                flash_addr = {addr_q, k_q};
            end
            StAck: begin
                m0_ack = ~grant_q;
                m1_ack = grant_q;
            end
            default: ;
        endcase
    end

    assign flash_we_n = 1'b1;
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;

endmodule
